// File: rtl/fir_ctrl_pkg.sv
// Shared types and helpers for the complex FIR sequencing controller.
package fir_ctrl_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        MAC   = 2'd1,
        DRAIN = 2'd2,
        WRITE = 2'd3
    } state_t;

    // Number of MAC cycles needed to cover all taps with the unrolled array.
    function automatic int unsigned ngroups(input int unsigned taps, input int unsigned unroll);
        return (taps + unroll - 1) / unroll;
    endfunction

endpackage

// File: rtl/fir_cmplx_ctrl.sv
// Sequencing controller for the complex FIR datapath: pops I/Q pairs,
// steps the unrolled MAC array over every tap group, waits out the MAC
// pipeline and pushes one real/imag result pair per DECIM input pairs.
module fir_cmplx_ctrl
    import fir_ctrl_pkg::*;
#(
    parameter int unsigned TAPS    = 20,
    parameter int unsigned UNROLL  = 4,
    parameter int unsigned DECIM   = 1,
    parameter int unsigned MAC_LAT = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_empty,
    input  logic                     q_empty,
    output logic                     i_rd_en,
    output logic                     q_rd_en,
    output logic                     shift_en,
    output logic                     mac_clr,
    output logic                     mac_en,
    output logic [$clog2(TAPS)-1:0]  tap_base,
    input  logic                     real_full,
    input  logic                     imag_full,
    output logic                     real_wr_en,
    output logic                     imag_wr_en,
    output logic                     busy,
    output logic [15:0]              out_count
);

    localparam int unsigned NGROUPS = ngroups(TAPS, UNROLL);
    localparam int unsigned TBW     = $clog2(TAPS);
    localparam int unsigned GW      = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;
    localparam int unsigned DW      = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int unsigned LW      = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

    state_t          state_q, state_d;
    logic [DW-1:0]   dec_cnt_q, dec_cnt_d;
    logic [GW-1:0]   grp_q, grp_d;
    logic [LW-1:0]   drain_q, drain_d;
    logic [15:0]     out_count_q, out_count_d;

    logic            pop_ok;
    logic            wr_ok;
    logic [31:0]     tap_full;

    assign pop_ok = (state_q == LOAD)  && !i_empty   && !q_empty;
    assign wr_ok  = (state_q == WRITE) && !real_full && !imag_full;

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= LOAD;
            dec_cnt_q   <= '0;
            grp_q       <= '0;
            drain_q     <= '0;
            out_count_q <= '0;
        end else begin
            state_q     <= state_d;
            dec_cnt_q   <= dec_cnt_d;
            grp_q       <= grp_d;
            drain_q     <= drain_d;
            out_count_q <= out_count_d;
        end
    end

    // Next-state and counter update; grp/drain clear whenever not advancing.
    always_comb begin
        state_d     = state_q;
        dec_cnt_d   = dec_cnt_q;
        grp_d       = '0;
        drain_d     = '0;
        out_count_d = out_count_q;
        unique case (state_q)
            LOAD: begin
                if (pop_ok) begin
                    if (dec_cnt_q == DW'(DECIM - 1)) begin
                        dec_cnt_d = '0;
                        state_d   = MAC;
                    end else begin
                        dec_cnt_d = dec_cnt_q + 1'b1;
                    end
                end
            end
            MAC: begin
                if (grp_q == GW'(NGROUPS - 1)) begin
                    state_d = (MAC_LAT == 0) ? WRITE : DRAIN;
                end else begin
                    grp_d = grp_q + 1'b1;
                end
            end
            DRAIN: begin
                if (drain_q == LW'(MAC_LAT - 1)) begin
                    state_d = WRITE;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            WRITE: begin
                if (wr_ok) begin
                    out_count_d = out_count_q + 16'd1;
                    state_d     = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // Output decode; FIFO strobes are also gated by reset so nothing moves while it is held.
    always_comb begin
        i_rd_en    = 1'b0;
        q_rd_en    = 1'b0;
        shift_en   = 1'b0;
        mac_en     = 1'b0;
        mac_clr    = 1'b0;
        tap_base   = '0;
        real_wr_en = 1'b0;
        imag_wr_en = 1'b0;
        tap_full   = 32'(grp_q) * UNROLL;
        if (pop_ok && !rst) begin
            i_rd_en  = 1'b1;
            q_rd_en  = 1'b1;
            shift_en = 1'b1;
        end
        if (state_q == MAC) begin
            mac_en   = 1'b1;
            mac_clr  = (grp_q == '0);
            tap_base = tap_full[TBW-1:0];
        end
        if (wr_ok && !rst) begin
            real_wr_en = 1'b1;
            imag_wr_en = 1'b1;
        end
    end

    assign busy      = (state_q != LOAD);
    assign out_count = out_count_q;

endmodule

// File: tb/tb_fir_cmplx_ctrl.sv
// Directed bench for fir_cmplx_ctrl: per-cycle vector table on a default
// instance, plus hand sequences for reset, decimation and zero-latency pipelining.
module tb_fir_cmplx_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Instance A: defaults
    logic a_ie = 1'b1, a_qe = 1'b1, a_rf = 1'b0, a_if = 1'b0;
    logic a_ird, a_qrd, a_sh, a_clr, a_mac, a_rwr, a_iwr, a_busy;
    logic [4:0]  a_tb;
    logic [15:0] a_oc;

    fir_cmplx_ctrl #(.TAPS(20), .UNROLL(4), .DECIM(1), .MAC_LAT(2)) dut_a (
        .clk(clk), .rst(rst), .i_empty(a_ie), .q_empty(a_qe),
        .i_rd_en(a_ird), .q_rd_en(a_qrd), .shift_en(a_sh), .mac_clr(a_clr),
        .mac_en(a_mac), .tap_base(a_tb), .real_full(a_rf), .imag_full(a_if),
        .real_wr_en(a_rwr), .imag_wr_en(a_iwr), .busy(a_busy), .out_count(a_oc)
    );

    // Instance B: DECIM=4
    logic b_e = 1'b1;
    logic b_ird, b_qrd, b_sh, b_clr, b_mac, b_rwr, b_iwr, b_busy;
    logic [4:0]  b_tb;
    logic [15:0] b_oc;

    fir_cmplx_ctrl #(.TAPS(20), .UNROLL(4), .DECIM(4), .MAC_LAT(2)) dut_b (
        .clk(clk), .rst(rst), .i_empty(b_e), .q_empty(b_e),
        .i_rd_en(b_ird), .q_rd_en(b_qrd), .shift_en(b_sh), .mac_clr(b_clr),
        .mac_en(b_mac), .tap_base(b_tb), .real_full(1'b0), .imag_full(1'b0),
        .real_wr_en(b_rwr), .imag_wr_en(b_iwr), .busy(b_busy), .out_count(b_oc)
    );

    // Instance C: MAC_LAT=0
    logic c_e = 1'b1;
    logic c_ird, c_qrd, c_sh, c_clr, c_mac, c_rwr, c_iwr, c_busy;
    logic [4:0]  c_tb;
    logic [15:0] c_oc;

    fir_cmplx_ctrl #(.TAPS(20), .UNROLL(4), .DECIM(1), .MAC_LAT(0)) dut_c (
        .clk(clk), .rst(rst), .i_empty(c_e), .q_empty(c_e),
        .i_rd_en(c_ird), .q_rd_en(c_qrd), .shift_en(c_sh), .mac_clr(c_clr),
        .mac_en(c_mac), .tap_base(c_tb), .real_full(1'b0), .imag_full(1'b0),
        .real_wr_en(c_rwr), .imag_wr_en(c_iwr), .busy(c_busy), .out_count(c_oc)
    );

    typedef struct {
        logic        ie, qe, rf, imf;
        logic        rd, mac, clr;
        logic [4:0]  tb;
        logic        wr, busy;
        logic [15:0] oc;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic ie, qe, rf, imf, rd, mac, clr,
                       input logic [4:0] tb, input logic wr, busy, input logic [15:0] oc);
        vec_t v;
        v.ie = ie; v.qe = qe; v.rf = rf; v.imf = imf;
        v.rd = rd; v.mac = mac; v.clr = clr; v.tb = tb;
        v.wr = wr; v.busy = busy; v.oc = oc;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [12:0] a_strobes();
        return {a_ird, a_qrd, a_sh, a_mac, a_clr, a_tb, a_rwr, a_iwr, a_busy};
    endfunction

    function automatic logic [12:0] pack_exp(input vec_t v);
        return {v.rd, v.rd, v.rd, v.mac, v.clr, v.tb, v.wr, v.wr, v.busy};
    endfunction

    int b_pops[$];
    int b_wrs[$];
    int c_wrs[$];
    int b_cnt;

    initial begin
        // Single pair through the default pipeline
        add(0,0,0,0, 1,0,0, 5'd0, 0,0, 16'd0);
        for (int g = 0; g < 5; g++) add(1,1,0,0, 0,1,(g == 0), 5'(4*g), 0,1, 16'd0);
        for (int d = 0; d < 2; d++) add(1,1,0,0, 0,0,0, 5'd0, 0,1, 16'd0);
        add(1,1,0,0, 0,0,0, 5'd0, 1,1, 16'd0);
        add(1,1,0,0, 0,0,0, 5'd0, 0,0, 16'd1);
        // Skewed input availability blocks the pair
        for (int s = 0; s < 10; s++) add(0,1,0,0, 0,0,0, 5'd0, 0,0, 16'd1);
        for (int s = 0; s < 2; s++)  add(1,0,0,0, 0,0,0, 5'd0, 0,0, 16'd1);
        add(0,0,0,0, 1,0,0, 5'd0, 0,0, 16'd1);
        for (int g = 0; g < 5; g++) add(0,0,0,0, 0,1,(g == 0), 5'(4*g), 0,1, 16'd1);
        for (int d = 0; d < 2; d++) add(0,0,0,0, 0,0,0, 5'd0, 0,1, 16'd1);
        // Output backpressure: either full holds WRITE, inputs ready but no pops
        for (int s = 0; s < 6; s++) add(0,0,0,1, 0,0,0, 5'd0, 0,1, 16'd1);
        for (int s = 0; s < 2; s++) add(0,0,1,0, 0,0,0, 5'd0, 0,1, 16'd1);
        add(0,0,0,0, 0,0,0, 5'd0, 1,1, 16'd1);
        add(0,0,0,0, 1,0,0, 5'd0, 0,0, 16'd2);
        for (int g = 0; g < 2; g++) add(1,1,0,0, 0,1,(g == 0), 5'(4*g), 0,1, 16'd2);

        // Reset state, with inputs ready to confirm strobes stay low
        a_ie = 1'b0; a_qe = 1'b0;
        #1;
        check("reset_strobes", 32'(a_strobes()), 32'd0);
        check("reset_count", 32'(a_oc), 32'd0);
        a_ie = 1'b1; a_qe = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            @(negedge clk);
            a_ie = tbl[i].ie; a_qe = tbl[i].qe; a_rf = tbl[i].rf; a_if = tbl[i].imf;
            #1;
            check($sformatf("vec%0d_strobes", i), 32'(a_strobes()), 32'(pack_exp(tbl[i])));
            check($sformatf("vec%0d_count", i), 32'(a_oc), 32'(tbl[i].oc));
        end

        // Asynchronous reset on the third MAC cycle
        @(negedge clk);
        a_ie = 1'b1; a_qe = 1'b1;
        #1;
        check("mid_mac_tap", 32'({a_mac, a_clr, a_tb}), 32'({1'b1, 1'b0, 5'd8}));
        a_ie = 1'b0; a_qe = 1'b0;
        rst = 1'b1;
        #1;
        check("async_rst_strobes", 32'(a_strobes()), 32'd0);
        check("async_rst_count", 32'(a_oc), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_pop", 32'(a_strobes()), 32'(13'b1110000000000));
        @(negedge clk);
        a_ie = 1'b1; a_qe = 1'b1;
        #1;
        for (int g = 0; g < 5; g++) begin
            check($sformatf("post_rst_mac%0d", g), 32'({a_mac, a_clr, a_tb}),
                  32'({1'b1, (g == 0), 5'(4*g)}));
            @(negedge clk);
            #1;
        end

        // Decimation and zero-latency instances run side by side
        rst = 1'b1;
        b_cnt = 8;
        @(negedge clk);
        rst = 1'b0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            b_e = (b_cnt == 0);
            c_e = 1'b0;
            #1;
            if (b_ird) begin
                b_pops.push_back(cyc);
                b_cnt--;
            end
            if (b_rwr) b_wrs.push_back(cyc);
            if (c_rwr) c_wrs.push_back(cyc);
            if (b_ird !== b_qrd) check("b_pair_rd", 32'(b_qrd), 32'(b_ird));
            if (c_rwr !== c_iwr) check("c_pair_wr", 32'(c_iwr), 32'(c_rwr));
        end
        check("b_pop_total", 32'(b_pops.size()), 32'd8);
        for (int i = 0; i < b_pops.size() && i < 8; i++)
            check($sformatf("b_pop%0d_cycle", i), 32'(b_pops[i]), 32'((i < 4) ? i : i + 8));
        check("b_wr_total", 32'(b_wrs.size()), 32'd2);
        for (int i = 0; i < b_wrs.size() && i < 2; i++)
            check($sformatf("b_wr%0d_cycle", i), 32'(b_wrs[i]), 32'(11 + 12*i));
        check("b_out_count", 32'(b_oc), 32'd2);
        check("b_idle", 32'(b_busy), 32'd0);
        check("c_wr_total", 32'(c_wrs.size()), 32'd8);
        for (int i = 0; i < c_wrs.size() && i < 8; i++)
            check($sformatf("c_wr%0d_cycle", i), 32'(c_wrs[i]), 32'(6 + 7*i));
        check("c_out_count", 32'(c_oc), 32'd8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard time bound in case the bench itself stalls
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
